// File: rtl/ans_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : ans_bcd_converter
//  Description : Converts a signed 32-bit calculator result into 10 BCD digits
//                of its magnitude plus sign and overflow flags.
//                Sequential double-dabble (shift-and-add-3), one bit per
//                cycle. The latency is a fixed 33 cycles from start to done.
//
//  Ports
//    sw_clk : in  1   sole clock, rising edge
//    rst    : in  1   synchronous, active-low reset
//    start  : in  1   one-cycle request to convert ans (ignored while busy)
//    ans    : in  32  signed two's-complement value
//    busy   : out 1   high from acceptance of start through the done cycle
//    done   : out 1   one-cycle pulse; bcd/neg/ovf update in this cycle
//    bcd    : out 40  10 BCD digits of |ans|, digit 0 in bcd[3:0]
//    neg    : out 1   sign of the converted value (never set for zero)
//    ovf    : out 1   |ans| > OVF_LIMIT
//
//  Revision    : 1.0  initial release
// ============================================================================
module ans_bcd_converter #(
    parameter logic [31:0] OVF_LIMIT = 32'd999999
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ans,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd,
    output logic        neg,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] C_LAST_ITER = 6'd31;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_mag;
    logic [39:0] r_scratch;
    logic        r_sign;
    logic        r_ovf_pend;

    logic [31:0] w_mag_in;
    logic [39:0] w_adj;
    logic [71:0] w_shifted;

    // Two's-complement magnitude. 0x8000_0000 negates to itself, which read
    // as unsigned is exactly 2147483648, so no special case is needed.
    assign w_mag_in = ans[31] ? (~ans + 32'd1) : ans;

    // Add-3 correction on every scratch digit that would exceed 9 once doubled.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                      (r_scratch[4*gi +: 4] + 4'd3) :
                                      r_scratch[4*gi +: 4];
        end
    endgenerate

    // Shift {scratch, magnitude} left by one. The top bit of the corrected
    // scratch is always zero because 2^32-1 needs only 10 decimal digits.
    assign w_shifted = {w_adj[38:0], r_mag, 1'b0};

    always_ff @(posedge sw_clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_mag      <= 32'd0;
            r_scratch  <= 40'd0;
            r_sign     <= 1'b0;
            r_ovf_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= 40'd0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mag      <= w_mag_in;
                        // A set sign bit always means a non-zero value; the
                        // explicit zero test keeps -0 impossible by design.
                        r_sign     <= ans[31] && (w_mag_in != 32'd0);
                        // Overflow is judged on the binary magnitude, so it
                        // is resolved once here rather than from the digits.
                        r_ovf_pend <= (w_mag_in > OVF_LIMIT);
                        r_scratch  <= 40'd0;
                        r_cnt      <= 6'd0;
                        busy       <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_scratch <= w_shifted[71:32];
                    r_mag     <= w_shifted[31:0];
                    r_cnt     <= r_cnt + 6'd1;
                    if (r_cnt == C_LAST_ITER) begin
                        // Results are published with the final shift so they
                        // appear in the same cycle as the done pulse.
                        bcd     <= w_shifted[71:32];
                        neg     <= r_sign;
                        ovf     <= r_ovf_pend;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ans_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ans_bcd_converter
//  Description : Scoreboard bench for ans_bcd_converter. Stimulus pushes the
//                expected result and the cycle it must appear in; a monitor
//                on the falling edge pops and compares on every done pulse,
//                and checks that outputs hold steady between pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ans_bcd_converter;

    localparam longint C_LIMIT = 999999;

    typedef struct {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
        int          due;
    } exp_t;

    logic        sw_clk;
    logic        rst;
    logic        start;
    logic [31:0] ans;
    logic        busy;
    logic        done;
    logic [39:0] bcd;
    logic        neg;
    logic        ovf;

    exp_t sb[$];
    int   cyc      = 0;
    int   next_ok  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rst_q    = 1'b0;
    logic prev_done = 1'b0;
    logic [39:0] hold_bcd = 40'd0;
    logic        hold_neg = 1'b0;
    logic        hold_ovf = 1'b0;

    ans_bcd_converter #(.OVF_LIMIT(32'd999999)) dut (
        .sw_clk (sw_clk),
        .rst    (rst),
        .start  (start),
        .ans    (ans),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .neg    (neg),
        .ovf    (ovf)
    );

    initial sw_clk = 1'b0;
    always #5 sw_clk = ~sw_clk;

    // Edge counter and the reset value the DUT saw at that edge.
    always @(posedge sw_clk) begin
        cyc++;
        rst_q = rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits of the magnitude by plain division.
    function automatic exp_t model(input logic [31:0] a);
        exp_t   e;
        longint v;
        longint m;
        v = longint'($signed(a));
        m = (v < 0) ? -v : v;
        e.neg = (v < 0);
        e.ovf = (m > C_LIMIT);
        e.bcd = '0;
        for (int i = 0; i < 10; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        e.due = 0;
        return e;
    endfunction

    // Monitor: compares on done, checks pulse width and output stability.
    always @(negedge sw_clk) begin
        exp_t e;
        if (!rst_q) begin
            sb.delete();
            hold_bcd = 40'd0;
            hold_neg = 1'b0;
            hold_ovf = 1'b0;
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check("done_missing_at_cycle", 64'(cyc), 64'(e.due));
        end
        if (done) begin
            check("done_width", {63'd0, prev_done}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("bcd", {24'd0, bcd}, {24'd0, e.bcd});
                check("neg", {63'd0, neg}, {63'd0, e.neg});
                check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                check("busy_in_done", {63'd0, busy}, 64'd1);
                hold_bcd = e.bcd;
                hold_neg = e.neg;
                hold_ovf = e.ovf;
            end
        end else begin
            check("hold_outputs", {22'd0, bcd, neg, ovf}, {22'd0, hold_bcd, hold_neg, hold_ovf});
        end
        prev_done = done;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sw_clk);
            #1;
        end
    endtask

    // Advance so that the next issue() is sampled at edge 'target'.
    task automatic goto_edge(input int target);
        while (cyc + 1 < target) idle(1);
    endtask

    // Drive start for one cycle; the model decides whether the DUT accepts it.
    task automatic issue(input logic [31:0] a, input logic [39:0] eb, input logic en, input logic eo);
        int e;
        e = cyc + 1;
        start = 1'b1;
        ans   = a;
        if (rst && e >= next_ok) begin
            sb.push_back('{eb, en, eo, e + 32});
            next_ok = e + 34;
        end
        @(posedge sw_clk);
        #1;
        start = 1'b0;
        ans   = $urandom;
    endtask

    task automatic issue_model(input logic [31:0] a);
        exp_t m;
        m = model(a);
        issue(a, m.bcd, m.neg, m.ovf);
    endtask

    logic [31:0] corner [8] = '{32'd0, 32'd999999, 32'd1000000, 32'hFFF0_BDC1,
                                32'hFFF0_BDC0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    initial begin
        int n0;
        logic [31:0] a;
        rst   = 1'b0;
        start = 1'b0;
        ans   = 32'd0;
        idle(3);
        // Start while in reset must be ignored.
        issue(32'd5, 40'd0, 1'b0, 1'b0);
        @(negedge sw_clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_bcd_neg_ovf", {22'd0, bcd, neg, ovf}, 64'd0);
        @(posedge sw_clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Directed values with hand-derived expectations.
        goto_edge(next_ok); issue(32'd0,         40'h00_0000_0000, 1'b0, 1'b0);
        n0 = cyc;
        idle(3);
        @(negedge sw_clk);
        check("busy_during_shift", {63'd0, busy}, 64'd1);
        @(posedge sw_clk); #1;
        goto_edge(next_ok); issue(32'd123456,    40'h00_0012_3456, 1'b0, 1'b0);
        goto_edge(next_ok); issue(32'd999999,    40'h00_0099_9999, 1'b0, 1'b0);
        goto_edge(next_ok); issue(32'd1000000,   40'h00_0100_0000, 1'b0, 1'b1);
        goto_edge(next_ok); issue(32'hFFFF_FFFF, 40'h00_0000_0001, 1'b1, 1'b0);
        goto_edge(next_ok); issue(32'h8000_0000, 40'h21_4748_3648, 1'b1, 1'b1);
        goto_edge(next_ok); issue(32'hFFF0_BDC1, 40'h00_0099_9999, 1'b1, 1'b0);

        // Start while busy is ignored; a start on the return-to-idle edge is taken.
        goto_edge(next_ok);
        n0 = cyc + 1;
        issue(32'd42, 40'h00_0000_0042, 1'b0, 1'b0);
        goto_edge(n0 + 5);
        issue(32'd7, 40'h00_0000_0007, 1'b0, 1'b0);
        goto_edge(n0 + 34);
        issue(32'd7, 40'h00_0000_0007, 1'b0, 1'b0);
        check("back_to_back_accept", 64'(next_ok), 64'(n0 + 68));
        goto_edge(next_ok + 2);
        @(negedge sw_clk);
        check("busy_idle", {63'd0, busy}, 64'd0);
        @(posedge sw_clk); #1;

        // Reset in the middle of a conversion aborts it without a done pulse.
        n0 = cyc + 1;
        issue(32'd555, 40'h00_0000_0555, 1'b0, 1'b0);
        goto_edge(n0 + 10);
        rst = 1'b0;
        @(posedge sw_clk); #1;
        @(negedge sw_clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_outputs", {22'd0, bcd, neg, ovf}, 64'd0);
        @(posedge sw_clk); #1;
        issue(32'd99, 40'd0, 1'b0, 1'b0);
        rst = 1'b1;
        next_ok = 0;
        idle(1);
        issue(32'd555, 40'h00_0000_0555, 1'b0, 1'b0);

        // Randomized conversions with occasional stray starts while busy.
        for (int k = 0; k < 1000; k++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = $urandom_range(0, 1100000);
                2: a = 32'(0 - int'($urandom_range(0, 1100000)));
                default: a = corner[$urandom_range(0, 7)];
            endcase
            goto_edge(next_ok + int'($urandom_range(0, 2)));
            issue_model(a);
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(0, 20)));
                issue_model($urandom);
            end
        end

        // Drain, bounded.
        for (int k = 0; k < 200 && sb.size() > 0; k++) idle(1);
        check("drain_pending", 64'(sb.size()), 64'd0);
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
